register_scheduler: RTL

- Sits between the decode/issue stage, the execution units and the register file write port.
- Keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards.
- Arbitrates NUM_WB execution-unit writeback requests onto the single register file write port, round-robin.
- Drives the register file w_valid/w_ad/w_data inputs through one register stage.

---
 rtl/register_scheduler_pkg.sv | 17 +
 rtl/register_scheduler_rr_arbiter.sv | 32 +++
 rtl/register_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/register_scheduler_pkg.sv
// Shared cpu definitions: register width, register index type and the
// writeback request bundle used around the register file write port.
package register_scheduler_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AD_W = 5;
   localparam int NUM_REGS = 32;

   typedef logic [REG_AD_W-1:0] reg_ad_t;

   typedef struct packed {
      logic            valid;
      reg_ad_t         ad;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/register_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps
// modulo N; the first requester found receives a one-hot grant.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any_grant
);

   logic [PTR_W-1:0] sel;

   // Walk the requesters from the pointer position and stop at the first hit
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      sel       = '0;
      for (int off = 0; off < N; off++) begin
         sel = PTR_W'((int'(ptr) + off) % N);
         if (!any_grant && req[sel]) begin
            any_grant  = 1'b1;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/register_scheduler.sv
// Register scheduler: busy scoreboard with RAW/WAW issue stall, round-robin
// writeback arbitration and a registered register-file write port.
module register_scheduler #(
   parameter int XLEN   = 32,
   parameter int NUM_WB = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   iss_valid_i,
   input  logic                   iss_rs1_v_i,
   input  logic [4:0]             iss_rs1_ad_i,
   input  logic                   iss_rs2_v_i,
   input  logic [4:0]             iss_rs2_ad_i,
   input  logic                   iss_rd_v_i,
   input  logic [4:0]             iss_rd_i,
   output logic                   iss_ready_o,
   input  logic [NUM_WB-1:0]      wb_valid_i,
   input  logic [NUM_WB*5-1:0]    wb_ad_i,
   input  logic [NUM_WB*XLEN-1:0] wb_data_i,
   output logic [NUM_WB-1:0]      wb_ready_o,
   output logic                   rf_w_valid_o,
   output logic [4:0]             rf_w_ad_o,
   output logic [XLEN-1:0]        rf_w_data_o,
   output logic [31:0]            busy_o,
   output logic                   err_o
);

   import register_scheduler_pkg::*;

   localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_n;
   logic [PTR_W-1:0]    rr_ptr;
   logic [NUM_WB-1:0]   grant;
   logic [PTR_W-1:0]    grant_idx;
   logic                any_grant;
   logic                hazard;
   logic                issue_fire;
   reg_ad_t             gnt_ad;
   logic [XLEN-1:0]     gnt_data;

   rr_arbiter #(
      .N     (NUM_WB),
      .PTR_W (PTR_W)
   ) u_arb (
      .req       (wb_valid_i),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Hazard check looks only at the registered scoreboard, no bypass
   always_comb begin
      hazard = (iss_rs1_v_i & busy_q[iss_rs1_ad_i])
             | (iss_rs2_v_i & busy_q[iss_rs2_ad_i])
             | (iss_rd_v_i  & busy_q[iss_rd_i]);
      issue_fire = iss_valid_i & ~hazard & ~flush_i;
   end

   // Pick the index and data of the granted writeback unit
   always_comb begin
      gnt_ad   = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_WB; i++) begin
         if (grant[i]) begin
            gnt_ad   = wb_ad_i[i*REG_AD_W +: REG_AD_W];
            gnt_data = wb_data_i[i*XLEN +: XLEN];
         end
      end
   end

   // Next scoreboard: flush wipes everything, otherwise clear then set so a younger issue wins
   always_comb begin
      busy_n = busy_q;
      if (flush_i) begin
         busy_n = '0;
      end else begin
         if (any_grant && gnt_ad != '0)
            busy_n[gnt_ad] = 1'b0;
         if (issue_fire && iss_rd_v_i && iss_rd_i != '0)
            busy_n[iss_rd_i] = 1'b1;
      end
      busy_n[0] = 1'b0;
   end

   // Scoreboard, round-robin pointer, error flag and register-file write stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= '0;
         rr_ptr       <= '0;
         err_o        <= 1'b0;
         rf_w_valid_o <= 1'b0;
         rf_w_ad_o    <= '0;
         rf_w_data_o  <= '0;
      end else begin
         busy_q       <= busy_n;
         rf_w_valid_o <= any_grant && (gnt_ad != '0);
         if (any_grant) begin
            rf_w_ad_o   <= gnt_ad;
            rf_w_data_o <= gnt_data;
            if (int'(grant_idx) == NUM_WB - 1)
               rr_ptr <= '0;
            else
               rr_ptr <= grant_idx + 1'b1;
            if (!flush_i && gnt_ad != '0 && !busy_q[gnt_ad])
               err_o <= 1'b1;
         end
      end
   end

   assign iss_ready_o = issue_fire;
   assign wb_ready_o  = grant;
   assign busy_o      = busy_q;

endmodule
